// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and architectural widths.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if;
    import cpu_pkg::*;

    // Handshake: mem_req is held high with a stable mem_addr until memory answers;
    // mem_ready is a single-cycle response carrying mem_rdata in that same cycle,
    // and mem_req drops the cycle after, so memory must not rely on it staying high.
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_watchdog.sv
// Wait-cycle counter for an outstanding fetch; flags the last permitted REQ cycle.
module fetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic            ARMED = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds the number of REQ cycles already completed, so the T-th cycle sees T-1.
    always_comb begin
        expired = ARMED && enable && (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, issues one instruction-memory read per request and
// strobes the fetched word into the instruction register.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       fetch_start,
    input  logic                       pc_load,
    input  logic [XLEN-1:0]            pc_load_value,
    instruction_fetch_unit_if.master   mem,
    output logic                       IR_Write,
    output logic [XLEN-1:0]            instr_data,
    output logic [XLEN-1:0]            pc,
    output logic                       busy,
    output logic                       fetch_fault,
    output fetch_state_t               dbg_state
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] tgt_q, tgt_d;

    logic [XLEN-1:0] load_tgt;
    logic            eff_pend;
    logic [XLEN-1:0] eff_tgt;
    logic            wd_expired;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != REQ),
        .enable  (state_q == REQ),
        .expired (wd_expired)
    );

    // A redirect arriving in the same cycle as the exit transition overrides any older pending one.
    always_comb begin
        load_tgt = {pc_load_value[XLEN-1:2], 2'b00};
        eff_pend = pend_q | pc_load;
        eff_tgt  = pc_load ? load_tgt : tgt_q;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;

        if (state_q != IDLE && pc_load) begin
            pend_d = 1'b1;
            tgt_d  = load_tgt;
        end

        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = load_tgt;
                end
                if (fetch_start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem.mem_ready) begin
                    state_d = DONE;
                    instr_d = mem.mem_rdata;
                    pc_d    = eff_pend ? eff_tgt : pc_q + XLEN'(INSTR_BYTES);
                    pend_d  = 1'b0;
                end else if (wd_expired) begin
                    state_d = FAULT;
                    if (eff_pend) begin
                        pc_d = eff_tgt;
                    end
                    pend_d = 1'b0;
                end
            end
            DONE, FAULT: begin
                state_d = IDLE;
                if (eff_pend) begin
                    pc_d = eff_tgt;
                end
                pend_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
        end
    end

    // The PC never moves while REQ is held, so it is also the in-flight fetch address.
    assign mem.mem_req  = (state_q == REQ);
    assign mem.mem_addr = pc_q;
    assign IR_Write     = (state_q == DONE);
    assign fetch_fault  = (state_q == FAULT);
    assign busy         = (state_q != IDLE);
    assign instr_data   = instr_q;
    assign pc           = pc_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: two instances (long and short timeout),
// expected IR_Write / fetch_fault events queued by the driver and checked by monitors.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  localparam int W = 66;  // {IR_Write, fetch_fault, instr_data, pc}

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        fetch_start;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_vec;
  int n_bad;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  instruction_fetch_unit_if a_bus ();
  instruction_fetch_unit_if b_bus ();

  logic         a_ir, a_ff, a_busy, b_ir, b_ff, b_busy;
  logic [31:0]  a_instr, a_pc, b_instr, b_pc;
  fetch_state_t a_state, b_state;

  assign a_bus.mem_ready = mem_ready & ~sel;
  assign b_bus.mem_ready = mem_ready & sel;
  assign a_bus.mem_rdata = mem_rdata;
  assign b_bus.mem_rdata = mem_rdata;

  instruction_fetch_unit #(.RESET_PC(32'h100), .TIMEOUT(16)) dut_a (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_start   (fetch_start & ~sel),
    .pc_load       (pc_load & ~sel),
    .pc_load_value (pc_load_value),
    .mem           (a_bus),
    .IR_Write      (a_ir),
    .instr_data    (a_instr),
    .pc            (a_pc),
    .busy          (a_busy),
    .fetch_fault   (a_ff),
    .dbg_state     (a_state)
  );

  instruction_fetch_unit #(.RESET_PC(32'h100), .TIMEOUT(4)) dut_b (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_start   (fetch_start & sel),
    .pc_load       (pc_load & sel),
    .pc_load_value (pc_load_value),
    .mem           (b_bus),
    .IR_Write      (b_ir),
    .instr_data    (b_instr),
    .pc            (b_pc),
    .busy          (b_busy),
    .fetch_fault   (b_ff),
    .dbg_state     (b_state)
  );

  logic         cur_req, cur_busy;
  logic [31:0]  cur_addr, cur_pc;
  fetch_state_t cur_state;
  assign cur_req   = sel ? b_bus.mem_req  : a_bus.mem_req;
  assign cur_addr  = sel ? b_bus.mem_addr : a_bus.mem_addr;
  assign cur_busy  = sel ? b_busy         : a_busy;
  assign cur_pc    = sel ? b_pc           : a_pc;
  assign cur_state = sel ? b_state        : a_state;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "tb timeout");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (a_ir || a_ff)) begin
      if (exp_a_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL a_unexpected_event: got ir=%0b ff=%0b pc=%0h expected no event", a_ir, a_ff, a_pc);
      end else begin
        check("a_event", {a_ir, a_ff, a_instr, a_pc}, exp_a_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && (b_ir || b_ff)) begin
      if (exp_b_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL b_unexpected_event: got ir=%0b ff=%0b pc=%0h expected no event", b_ir, b_ff, b_pc);
      end else begin
        check("b_event", {b_ir, b_ff, b_instr, b_pc}, exp_b_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lat = REQ cycle carrying mem_ready (0 = never); *_at = REQ cycle of the pulse (0 = none).
  task automatic run_fetch(input logic        to_b,
                           input int          lat,
                           input logic [31:0] rdata,
                           input logic [31:0] start_addr,
                           input int          exp_req,
                           input logic [W-1:0] exp_ev,
                           input logic        idle_ld,
                           input logic [31:0] idle_val,
                           input int          poke_at,
                           input int          ld_at,
                           input logic [31:0] ld_val,
                           input int          ld2_at,
                           input logic [31:0] ld2_val);
    int k;
    int req_n;
    sel = to_b;
    if (to_b) exp_b_q.push_back(exp_ev);
    else      exp_a_q.push_back(exp_ev);
    fetch_start   = 1'b1;
    pc_load       = idle_ld;
    pc_load_value = idle_val;
    step();
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    check("req_addr", {33'd0, cur_req, cur_addr}, {33'd0, 1'b1, start_addr});
    k     = 1;
    req_n = 0;
    while (cur_req && k <= 40) begin
      req_n++;
      mem_ready     = (k == lat);
      mem_rdata     = rdata;
      fetch_start   = (k == poke_at);
      pc_load       = (k == ld_at) || (k == ld2_at);
      pc_load_value = (k == ld2_at) ? ld2_val : ld_val;
      step();
      k++;
    end
    mem_ready   = 1'b0;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    check("req_cycles", W'(req_n), W'(exp_req));
    step();
    check("back_to_idle", {63'd0, cur_busy, cur_state}, {63'd0, 1'b0, IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec         = 0;
    n_bad         = 0;
    sel           = 1'b0;
    fetch_start   = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    mem_ready     = 1'b0;
    mem_rdata     = '0;
    reset_n       = 1'b0;
    repeat (3) step();

    check("rst_pc",    W'(a_pc), W'(32'h100));
    check("rst_addr",  W'(a_bus.mem_addr), W'(32'h100));
    check("rst_instr", W'(a_instr), W'(0));
    check("rst_flags", W'({a_bus.mem_req, a_ir, a_busy, a_ff}), W'(0));
    check("rst_state", W'(a_state), W'(IDLE));
    check("rst_b_pc",  W'(b_pc), W'(32'h100));
    reset_n = 1'b1;
    step();

    // single-cycle memory, then latency 5 with an ignored start while busy
    run_fetch(1'b0, 1, 32'hDEADBEEF, 32'h100, 1, {2'b10, 32'hDEADBEEF, 32'h104},
              1'b0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    run_fetch(1'b0, 5, 32'h11111111, 32'h104, 5, {2'b10, 32'h11111111, 32'h108},
              1'b0, 32'h0, 2, 0, 32'h0, 0, 32'h0);
    // redirect during REQ, then two redirects where the later wins
    run_fetch(1'b0, 3, 32'h22222222, 32'h108, 3, {2'b10, 32'h22222222, 32'h2000},
              1'b0, 32'h0, 0, 1, 32'h2003, 0, 32'h0);
    run_fetch(1'b0, 4, 32'h33333333, 32'h2000, 4, {2'b10, 32'h33333333, 32'h3000},
              1'b0, 32'h0, 0, 1, 32'h4003, 3, 32'h3000);
    // idle load together with start, address aligned, PC wraps to 0
    run_fetch(1'b0, 2, 32'h44444444, 32'hFFFFFFFC, 2, {2'b10, 32'h44444444, 32'h0},
              1'b1, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 32'h0);

    // short-timeout instance: plain timeout, ready on the last cycle, timeout with redirect
    run_fetch(1'b1, 0, 32'h55555555, 32'h100, 4, {2'b01, 32'h0, 32'h100},
              1'b0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    run_fetch(1'b1, 4, 32'hCAFEF00D, 32'h100, 4, {2'b10, 32'hCAFEF00D, 32'h104},
              1'b0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    run_fetch(1'b1, 0, 32'h66666666, 32'h104, 4, {2'b01, 32'hCAFEF00D, 32'h500},
              1'b0, 32'h0, 0, 2, 32'h503, 0, 32'h0);

    // reset in the middle of a fetch
    sel         = 1'b0;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("mid_req_up", W'(a_bus.mem_req), W'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req",   W'(a_bus.mem_req), W'(0));
    check("mid_rst_pc",    W'(a_pc), W'(32'h100));
    check("mid_rst_state", W'({a_busy, a_state}), W'({1'b0, IDLE}));
    step();
    reset_n = 1'b1;
    step();
    run_fetch(1'b0, 1, 32'h77777777, 32'h100, 1, {2'b10, 32'h77777777, 32'h104},
              1'b0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

    repeat (3) step();
    check("a_drain", W'(exp_a_q.size()), W'(0));
    check("b_drain", W'(exp_b_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
